// File: rtl/vga_pkg.sv
// Shared VGA timing constants, FSM state types and counter helper.
// Latency: n/a (package).
// Backpressure: n/a; the raster is free-running.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE_DEF   = 640;
    localparam int H_FP_DEF       = 16;
    localparam int H_SYNC_DEF     = 96;
    localparam int H_BP_DEF       = 48;
    localparam int V_ACTIVE_DEF   = 480;
    localparam int V_FP_DEF       = 10;
    localparam int V_SYNC_DEF     = 2;
    localparam int V_BP_DEF       = 33;
    localparam int PIPE_DELAY_DEF = 1;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Idle value of the {blank, hs_n, vs_n} bundle: not visible, syncs deasserted.
    localparam logic [2:0] SYNC_IDLE = 3'b011;

    typedef enum logic [1:0] {
        H_ST_ACT,
        H_ST_FP,
        H_ST_SYNC,
        H_ST_BP
    } h_state_t;

    typedef enum logic [1:0] {
        V_ST_ACT,
        V_ST_FP,
        V_ST_SYNC,
        V_ST_BP
    } v_state_t;

    // Wrap is an explicit compare-and-clear so non power-of-two totals work.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic [CNT_W-1:0] last);
        return (cnt == last) ? '0 : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line with a programmable reset value.
// Latency: DEPTH cycles (DEPTH = 0 is a straight wire).
// Backpressure: none; shifts every cycle.
module vga_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = vga_clk ^ reset_n;
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RST_VAL;
                    end
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, H/V phase FSMs, syncs, blank and delayed copies.
// Latency: all outputs registered; *_d outputs lag their sources by PIPE_DELAY cycles.
// Backpressure: none; free-running on vga_clk.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int PIPE_DELAY = PIPE_DELAY_DEF
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    output logic [CNT_W-1:0] DrawX,
    output logic [CNT_W-1:0] DrawY,
    output logic             blank,
    output logic             hs_n,
    output logic             vs_n,
    output logic             line_start,
    output logic             frame_start,
    output logic             blank_d,
    output logic             hs_n_d,
    output logic             vs_n_d
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_FP_X     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_X   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_BP_X     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_FP_Y     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_Y   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_BP_Y     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    h_state_t         h_state, h_nxt;
    v_state_t         v_state, v_nxt;
    logic             x_wrap;
    logic [CNT_W-1:0] x_nxt, y_nxt;
    logic [2:0]       dly_out;

    // Next-cycle position and phase; outputs are decoded from these so they
    // leave the flops aligned with DrawX/DrawY.
    always_comb begin
        x_wrap = (DrawX == H_LAST);
        x_nxt  = cnt_next(DrawX, H_LAST);
        y_nxt  = x_wrap ? cnt_next(DrawY, V_LAST) : DrawY;

        h_nxt = h_state;
        if (x_nxt == '0) begin
            h_nxt = H_ST_ACT;
        end else if (x_nxt == H_FP_X) begin
            h_nxt = H_ST_FP;
        end else if (x_nxt == H_SYNC_X) begin
            h_nxt = H_ST_SYNC;
        end else if (x_nxt == H_BP_X) begin
            h_nxt = H_ST_BP;
        end

        v_nxt = v_state;
        if (x_wrap) begin
            if (y_nxt == '0) begin
                v_nxt = V_ST_ACT;
            end else if (y_nxt == V_FP_Y) begin
                v_nxt = V_ST_FP;
            end else if (y_nxt == V_SYNC_Y) begin
                v_nxt = V_ST_SYNC;
            end else if (y_nxt == V_BP_Y) begin
                v_nxt = V_ST_BP;
            end
        end
    end

    // Reset parks the raster on the last pixel of the frame so the first
    // clock after release lands on (0,0).
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= H_LAST;
            DrawY       <= V_LAST;
            h_state     <= H_ST_BP;
            v_state     <= V_ST_BP;
            blank       <= 1'b0;
            hs_n        <= 1'b1;
            vs_n        <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            DrawX       <= x_nxt;
            DrawY       <= y_nxt;
            h_state     <= h_nxt;
            v_state     <= v_nxt;
            blank       <= (h_nxt == H_ST_ACT) && (v_nxt == V_ST_ACT);
            hs_n        <= (h_nxt != H_ST_SYNC);
            vs_n        <= (v_nxt != V_ST_SYNC);
            line_start  <= (x_nxt == '0);
            frame_start <= (x_nxt == '0) && (y_nxt == '0);
        end
    end

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (SYNC_IDLE)
    ) u_delay (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .din     ({blank, hs_n, vs_n}),
        .dout    (dly_out)
    );

    assign {blank_d, hs_n_d, vs_n_d} = dly_out;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default-timing instance plus two shrunk-raster
// instances (PIPE_DELAY 0 and 3) checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    localparam int S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
    localparam int S_VA = 10, S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
    localparam int S_FRAME = S_HT * S_VT;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs_n;
        logic       vs_n;
        logic       ls;
        logic       fs;
    } obs_t;

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [9:0] dx [3];
    logic [9:0] dy [3];
    logic       bl [3];
    logic       hsn [3];
    logic       vsn [3];
    logic       ls [3];
    logic       fs [3];
    logic       bld [3];
    logic       hsnd [3];
    logic       vsnd [3];

    int   k = -1;
    int   nvec = 0;
    int   nerr = 0;
    int   last_ls, last_fs, bl_cnt, vs_cnt;
    logic prev_hs, prev_vs;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen #(.PIPE_DELAY(1)) u_def (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[0]), .DrawY(dy[0]),
        .blank(bl[0]), .hs_n(hsn[0]), .vs_n(vsn[0]), .line_start(ls[0]),
        .frame_start(fs[0]), .blank_d(bld[0]), .hs_n_d(hsnd[0]), .vs_n_d(vsnd[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .PIPE_DELAY(0)
    ) u_s0 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[1]), .DrawY(dy[1]),
        .blank(bl[1]), .hs_n(hsn[1]), .vs_n(vsn[1]), .line_start(ls[1]),
        .frame_start(fs[1]), .blank_d(bld[1]), .hs_n_d(hsnd[1]), .vs_n_d(vsnd[1])
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .PIPE_DELAY(3)
    ) u_s3 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[2]), .DrawY(dy[2]),
        .blank(bl[2]), .hs_n(hsn[2]), .vs_n(vsn[2]), .line_start(ls[2]),
        .frame_start(fs[2]), .blank_d(bld[2]), .hs_n_d(hsnd[2]), .vs_n_d(vsnd[2])
    );

    // Raster state kk cycles after reset release (kk < 0: held in reset).
    function automatic obs_t model(input int cfg, input int kk);
        int   ha, hfp, hsw, hbp, va, vfp, vsw, vbp, ht, vt, x, y;
        obs_t m;
        if (cfg == 0) begin
            ha = 640; hfp = 16; hsw = 96; hbp = 48; va = 480; vfp = 10; vsw = 2; vbp = 33;
        end else begin
            ha = S_HA; hfp = S_HFP; hsw = S_HS; hbp = S_HBP;
            va = S_VA; vfp = S_VFP; vsw = S_VS; vbp = S_VBP;
        end
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        if (kk < 0) begin
            x = ht - 1;
            y = vt - 1;
        end else begin
            x = kk % ht;
            y = (kk / ht) % vt;
        end
        m.x     = 10'(x);
        m.y     = 10'(y);
        m.blank = (kk >= 0) && (x < ha) && (y < va);
        m.hs_n  = (kk < 0) || !((x >= ha + hfp) && (x < ha + hfp + hsw));
        m.vs_n  = (kk < 0) || !((y >= va + vfp) && (y < va + vfp + vsw));
        m.ls    = (kk >= 0) && (x == 0);
        m.fs    = (kk >= 0) && (x == 0) && (y == 0);
        return m;
    endfunction

    task automatic chk(input int inst, input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL u%0d.%s k=%0d observed %0d expected %0d", inst, tag, k, obs, exp);
        end
    endtask

    task automatic clear_trackers();
        k       = -1;
        last_ls = -1;
        last_fs = -1;
        bl_cnt  = 0;
        vs_cnt  = 0;
        prev_hs = 1'b1;
        prev_vs = 1'b1;
    endtask

    task automatic check_all();
        obs_t e, ed;
        int   pd, cfg;
        for (int i = 0; i < 3; i++) begin
            pd  = (i == 0) ? 1 : ((i == 1) ? 0 : 3);
            cfg = (i == 0) ? 0 : 1;
            e   = model(cfg, k);
            ed  = model(cfg, k - pd);
            chk(i, "DrawX",       32'(dx[i]),  32'(e.x));
            chk(i, "DrawY",       32'(dy[i]),  32'(e.y));
            chk(i, "blank",       32'(bl[i]),  32'(e.blank));
            chk(i, "hs_n",        32'(hsn[i]), 32'(e.hs_n));
            chk(i, "vs_n",        32'(vsn[i]), 32'(e.vs_n));
            chk(i, "line_start",  32'(ls[i]),  32'(e.ls));
            chk(i, "frame_start", 32'(fs[i]),  32'(e.fs));
            chk(i, "blank_d",     32'(bld[i]), 32'(ed.blank));
            chk(i, "hs_n_d",      32'(hsnd[i]), 32'(ed.hs_n));
            chk(i, "vs_n_d",      32'(vsnd[i]), 32'(ed.vs_n));
        end

        // Edge/period properties observed directly on the outputs.
        if (prev_hs && !hsn[0]) chk(0, "hs_fall_x", 32'(dx[0]), 656);
        if (!prev_hs && hsn[0]) chk(0, "hs_rise_x", 32'(dx[0]), 752);
        prev_hs = hsn[0];
        if (ls[0]) begin
            if (last_ls >= 0) chk(0, "ls_period", k - last_ls, 800);
            last_ls = k;
        end
        if (fs[1]) begin
            if (last_fs >= 0) chk(1, "fs_period", k - last_fs, S_FRAME);
            last_fs = k;
        end
        if (k >= 0 && k < 800 && bl[0]) bl_cnt++;
        if (k == 799) chk(0, "blank_per_line", bl_cnt, 640);
        if (k >= 0 && k < S_FRAME && !vsn[1]) vs_cnt++;
        if (k == S_FRAME - 1) chk(1, "vs_low_cycles", vs_cnt, S_VS * S_HT);
        if (prev_vs && !vsn[1]) begin
            chk(1, "vs_fall_x", 32'(dx[1]), 0);
            chk(1, "vs_fall_y", 32'(dy[1]), S_VA + S_VFP);
        end
        prev_vs = vsn[1];
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            k++;
            @(negedge vga_clk);
            check_all();
        end
    endtask

    // Reset lands between edges so the reset state is seen before any clock.
    task automatic async_reset(input int hold);
        @(posedge vga_clk);
        #2;
        reset_n = 1'b0;
        #1;
        clear_trackers();
        check_all();
        repeat (hold) begin
            @(negedge vga_clk);
            check_all();
        end
        reset_n = 1'b1;
    endtask

    initial begin
        clear_trackers();
        #1 reset_n = 1'b0;
        repeat (3) begin
            @(negedge vga_clk);
            check_all();
        end
        reset_n = 1'b1;

        run(3000);

        // Mid-line reset at DrawX = 300 on the default raster.
        run(501);
        chk(0, "pre_reset_x", 32'(dx[0]), 300);
        async_reset(3);
        run(1200);

        for (int r = 0; r < 6; r++) begin
            run(int'($urandom_range(1, 1500)));
            async_reset(int'($urandom_range(1, 5)));
        end
        run(2 * S_FRAME + 50);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
